// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared load encodings, writeback FSM states and datapath width
package core_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } wb_state_t;

endpackage

// File: rtl/core_load_align.sv
// rtl/core_load_align.sv - combinational load byte/half/word extraction, extension and legality check
module core_load_align
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rdata,
    output logic [XLEN-1:0] o_data,
    output logic            o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Byte lane picked by both address bits, half lane by addr[1] only.
    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Decode size/sign; reserved encodings and misaligned halves/words raise the error flag.
    always_comb begin
        o_data = '0;
        o_err  = 1'b0;
        case (i_funct3)
            F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
            F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
            F3_LH: begin
                o_data = {{(XLEN-16){w_half[15]}}, w_half};
                o_err  = i_addr_lo[0];
            end
            F3_LHU: begin
                o_data = {{(XLEN-16){1'b0}}, w_half};
                o_err  = i_addr_lo[0];
            end
            F3_LW: begin
                o_data = i_rdata;
                o_err  = (i_addr_lo != 2'b00);
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/core_wb_stage.sv
// rtl/core_wb_stage.sv - writeback stage with load wait/timeout; CORE_WB_INSTRET_EN adds instret_o
module core_wb_stage
    import core_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid_i,
    output logic            wb_ready_o,
    input  logic [4:0]      wb_rd_i,
    input  logic            wb_we_i,
    input  logic            wb_load_i,
    input  logic [2:0]      wb_funct3_i,
    input  logic [1:0]      wb_addr_lo_i,
    input  logic [XLEN-1:0] wb_result_i,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic            rf_we_o,
    output logic [4:0]      rf_rd_o,
    output logic [XLEN-1:0] rf_data_o,
    output logic            load_err_o
`ifdef CORE_WB_INSTRET_EN
    ,
    output logic [31:0]     instret_o
`endif
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    wb_state_t       r_state;
    wb_state_t       w_state_nxt;
    logic            r_we;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_data;
    logic            r_err;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_ld_rd;
    logic            r_ld_we;
    logic [2:0]      r_ld_funct3;
    logic [1:0]      r_ld_addr;

    logic            w_idle;
    logic            w_accept;
    logic [2:0]      w_funct3;
    logic [1:0]      w_addr;
    logic [XLEN-1:0] w_ld_data;
    logic            w_ld_err;
    logic            w_alu_acc;
    logic            w_ld_ok;
    logic            w_ld_bad;
    logic            w_ack_done;
    logic            w_timeout;

    assign w_idle     = (r_state == IDLE);
    assign wb_ready_o = w_idle;
    assign w_accept   = wb_valid_i && w_idle;

    // One aligner serves the accept-time check in IDLE and the extraction while waiting.
    assign w_funct3 = w_idle ? wb_funct3_i  : r_ld_funct3;
    assign w_addr   = w_idle ? wb_addr_lo_i : r_ld_addr;

    core_load_align #(.XLEN(XLEN)) u_align (
        .i_funct3  (w_funct3),
        .i_addr_lo (w_addr),
        .i_rdata   (dmem_rdata_i),
        .o_data    (w_ld_data),
        .o_err     (w_ld_err)
    );

    assign w_alu_acc  = w_accept && !wb_load_i;
    assign w_ld_ok    = w_accept && wb_load_i && !w_ld_err;
    assign w_ld_bad   = w_accept && wb_load_i && w_ld_err;
    assign w_ack_done = !w_idle && dmem_ack_i;
    assign w_timeout  = (TIMEOUT > 0) && !w_idle && !dmem_ack_i && (r_cnt == TO_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: enter WAIT_RESP on a legal load, leave on ack (which beats timeout) or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_ld_ok) w_state_nxt = WAIT_RESP;
            WAIT_RESP: if (w_ack_done || w_timeout) w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    // Registered write port, error pulse, load context and wait counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_rd        <= '0;
            r_data      <= '0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_ld_rd     <= '0;
            r_ld_we     <= 1'b0;
            r_ld_funct3 <= '0;
            r_ld_addr   <= '0;
        end else begin
            r_we  <= 1'b0;
            r_err <= 1'b0;
            if (w_alu_acc && wb_we_i && (wb_rd_i != 5'd0)) begin
                r_we   <= 1'b1;
                r_rd   <= wb_rd_i;
                r_data <= wb_result_i;
            end
            if (w_ld_bad) r_err <= 1'b1;
            if (w_ld_ok) begin
                r_ld_rd     <= wb_rd_i;
                r_ld_we     <= wb_we_i;
                r_ld_funct3 <= wb_funct3_i;
                r_ld_addr   <= wb_addr_lo_i;
                r_cnt       <= '0;
            end
            if (w_ack_done) begin
                if (r_ld_we && (r_ld_rd != 5'd0)) begin
                    r_we   <= 1'b1;
                    r_rd   <= r_ld_rd;
                    r_data <= w_ld_data;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end else if (!w_idle) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign rf_we_o    = r_we;
    assign rf_rd_o    = r_rd;
    assign rf_data_o  = r_data;
    assign load_err_o = r_err;

`ifdef CORE_WB_INSTRET_EN
    logic [31:0] r_instret;

    // Retired count: accepted non-loads plus loads finished by ack; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       r_instret <= '0;
        else if (w_alu_acc || w_ack_done) r_instret <= r_instret + 32'd1;
    end

    assign instret_o = r_instret;
`endif

endmodule
